// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, error codes
// and the bus FSM state type.
//
// Contents:
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD  mem_size encodings (3 behaves as word)
//   ERR_NONE / ERR_MISALIGN / ERR_TIMEOUT  err_code values
//   state_e  {IDLE, WAIT} bus transaction state
//   norm_size()  folds the reserved size encoding onto word
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic for the MEM stage.
//
// Store side (from the current EX/MEM inputs):
//   st_addr_lo, st_size, st_data -> st_be, st_wdata, misaligned
// Load side (address/size may come from the captured request):
//   ld_addr_lo, ld_size, ld_unsigned, ld_rdata -> ld_data (aligned, extended)
module mem_lane_align (
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        misaligned,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  import mem_pkg::*;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Byte enables and lane-replicated write data; the replication lets the
  // slave pick up the data on whichever lane the enables select.
  always_comb begin
    st_be      = '0;
    st_wdata   = '0;
    misaligned = 1'b0;
    unique case (norm_size(st_size))
      SIZE_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        st_be      = 4'b0011 << st_addr_lo;
        st_wdata   = {2{st_data[15:0]}};
        misaligned = st_addr_lo[0];
      end
      default: begin
        st_be      = 4'hF;
        st_wdata   = st_data;
        misaligned = |st_addr_lo;
      end
    endcase
  end

  always_comb begin
    unique case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    unique case (norm_size(ld_size))
      SIZE_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default:   ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Converts load/store control from
// EX/MEM into a request/ready data-memory transaction, aligns load data,
// stalls upstream while a transfer is outstanding and keeps a sticky log of
// the first misalignment or bus-timeout error.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   alu_out .. mem_unsigned     EX/MEM inputs (address, store data, control)
//   dmem_*                      data-memory bus (req/ready handshake)
//   read_data, *_o              results to MEM/WB (reg_write_o bubble-gated)
//   stall                       freezes PC, IF/ID, ID/EX, EX/MEM
//   err_valid/code/addr, err_clr  sticky error log and its clear
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic [4:0]  reg_wr_addr,
  input  logic        reg_write,
  input  logic        memto_reg,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] dmem_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] read_data,
  output logic [31:0] alu_out_o,
  output logic [4:0]  reg_wr_addr_o,
  output logic        memto_reg_o,
  output logic        reg_write_o,
  output logic        stall,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr,
  input  logic        err_clr
);
  import mem_pkg::*;

  // The wait counter starts at 0 on the first WAIT cycle; the IDLE request
  // cycle already counts as one stall, so the last allowed WAIT cycle is
  // TIMEOUT-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_we_q, req_we_d;
  logic [3:0]  req_be_q, req_be_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [1:0]  req_size_q, req_size_d;
  logic        req_unsigned_q, req_unsigned_d;
  logic        err_valid_q, err_valid_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        access;
  logic        idle_req;
  logic        misalign_evt;
  logic        timeout_cycle;
  logic        load_done;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_misaligned;
  logic [1:0]  ld_lo;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [31:0] al_ld_data;

  // Gating with reset makes an abandoned request vanish at once even while
  // the frozen EX/MEM register still presents the access.
  assign access        = (mem_read | mem_write) & ~reset;
  assign idle_req      = (state_q == IDLE) & access & ~al_misaligned;
  assign misalign_evt  = (state_q == IDLE) & access & al_misaligned;
  assign timeout_cycle = (state_q == WAIT) & ~dmem_ready & (cnt_q == TO_LAST);

  // Load formatting uses the captured request while waiting.
  assign ld_lo       = (state_q == WAIT) ? req_addr_q[1:0] : alu_out[1:0];
  assign ld_size     = (state_q == WAIT) ? req_size_q      : mem_size;
  assign ld_unsigned = (state_q == WAIT) ? req_unsigned_q  : mem_unsigned;

  mem_lane_align u_align (
    .st_addr_lo  (alu_out[1:0]),
    .st_size     (mem_size),
    .st_data     (store_data),
    .st_be       (al_be),
    .st_wdata    (al_wdata),
    .misaligned  (al_misaligned),
    .ld_addr_lo  (ld_lo),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .ld_rdata    (dmem_rdata),
    .ld_data     (al_ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      req_addr_q     <= '0;
      req_we_q       <= 1'b0;
      req_be_q       <= '0;
      req_wdata_q    <= '0;
      req_size_q     <= '0;
      req_unsigned_q <= 1'b0;
      err_valid_q    <= 1'b0;
      err_code_q     <= ERR_NONE;
      err_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_addr_q     <= req_addr_d;
      req_we_q       <= req_we_d;
      req_be_q       <= req_be_d;
      req_wdata_q    <= req_wdata_d;
      req_size_q     <= req_size_d;
      req_unsigned_q <= req_unsigned_d;
      err_valid_q    <= err_valid_d;
      err_code_q     <= err_code_d;
      err_addr_q     <= err_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_addr_d     = req_addr_q;
    req_we_d       = req_we_q;
    req_be_d       = req_be_q;
    req_wdata_d    = req_wdata_q;
    req_size_d     = req_size_q;
    req_unsigned_d = req_unsigned_q;
    unique case (state_q)
      IDLE: begin
        if (idle_req && !dmem_ready) begin
          state_d        = WAIT;
          cnt_d          = '0;
          req_addr_d     = alu_out;
          req_we_d       = mem_write;
          req_be_d       = al_be;
          req_wdata_d    = al_wdata;
          req_size_d     = mem_size;
          req_unsigned_d = mem_unsigned;
        end
      end
      WAIT: begin
        if (dmem_ready || timeout_cycle) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // First error wins; a clear in the same cycle beats a new error.
  always_comb begin
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;
    if (err_clr) begin
      err_valid_d = 1'b0;
      err_code_d  = ERR_NONE;
      err_addr_d  = '0;
    end else if (!err_valid_q) begin
      if (misalign_evt) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_MISALIGN;
        err_addr_d  = alu_out;
      end else if (timeout_cycle) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        err_addr_d  = req_addr_q;
      end
    end
  end

  always_comb begin
    dmem_req   = 1'b0;
    dmem_addr  = '0;
    dmem_we    = 1'b0;
    dmem_be    = '0;
    dmem_wdata = '0;
    load_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem_req   = idle_req;
        dmem_addr  = {alu_out[31:2], 2'b00};
        dmem_we    = mem_write;
        dmem_be    = al_be;
        dmem_wdata = al_wdata;
        load_done  = idle_req & ~mem_write & dmem_ready;
      end
      WAIT: begin
        dmem_req   = ~timeout_cycle;
        dmem_addr  = {req_addr_q[31:2], 2'b00};
        dmem_we    = req_we_q;
        dmem_be    = req_be_q;
        dmem_wdata = req_wdata_q;
        load_done  = ~req_we_q & dmem_ready;
      end
    endcase
    stall       = dmem_req & ~dmem_ready;
    read_data   = load_done ? al_ld_data : '0;
    reg_write_o = reg_write & ~stall & ~misalign_evt & ~timeout_cycle;
  end

  assign alu_out_o     = alu_out;
  assign reg_wr_addr_o = reg_wr_addr;
  assign memto_reg_o   = memto_reg;

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_out, store_data, dmem_rdata;
  logic [4:0]  reg_wr_addr;
  logic        reg_write, memto_reg, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic        dmem_ready, err_clr;
  logic [31:0] dmem_addr, dmem_wdata, read_data, alu_out_o, err_addr;
  logic        dmem_req, dmem_we, memto_reg_o, reg_write_o, stall, err_valid;
  logic [3:0]  dmem_be;
  logic [4:0]  reg_wr_addr_o;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .alu_out(alu_out), .store_data(store_data),
    .reg_wr_addr(reg_wr_addr), .reg_write(reg_write), .memto_reg(memto_reg),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .dmem_addr(dmem_addr), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .read_data(read_data),
    .alu_out_o(alu_out_o), .reg_wr_addr_o(reg_wr_addr_o),
    .memto_reg_o(memto_reg_o), .reg_write_o(reg_write_o), .stall(stall),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr),
    .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
  endtask

  // Current transaction as the model sees it: cycle m_k of an access whose
  // slave answers after m_n wait states.
  logic        m_rd = 0, m_wr = 0, m_uns = 0, m_rw = 1, m_clr = 0, pend_clr = 0;
  logic [1:0]  m_size = 0;
  logic [31:0] m_addr = 0, m_sd = 0, m_rdata = 0;
  logic [4:0]  m_wa = 0;
  int          m_n = 0, m_k = 0;
  bit          chk_en = 0;

  logic        sh_v = 0;
  logic [1:0]  sh_code = 0;
  logic [31:0] sh_addr = 0;

  function automatic int eff_size();
    return (m_size == 2'd3) ? 2 : int'(m_size);
  endfunction
  function automatic bit m_acc();
    return m_rd | m_wr;
  endfunction
  function automatic bit m_mis();
    int lo = int'(m_addr[1:0]);
    return m_acc() && ((eff_size() == 1 && lo % 2 != 0) || (eff_size() == 2 && lo != 0));
  endfunction
  function automatic bit m_go();
    return m_acc() && !m_mis();
  endfunction
  function automatic bit timed_out();
    return m_n > int'(TO);
  endfunction
  function automatic int done_k();
    return timed_out() ? int'(TO) : m_n;
  endfunction
  function automatic int last_k();
    return m_go() ? done_k() : 0;
  endfunction
  function automatic bit e_stall();
    return m_go() && m_k < done_k();
  endfunction
  function automatic bit e_tocyc();
    return m_go() && timed_out() && m_k == done_k();
  endfunction
  function automatic bit e_req();
    return e_stall() || (m_go() && !timed_out() && m_k == done_k());
  endfunction
  function automatic bit e_rwo();
    return m_rw && !e_stall() && !m_mis() && !e_tocyc();
  endfunction
  function automatic logic [31:0] e_rdata();
    logic [31:0] v;
    if (!(m_go() && !m_wr && !timed_out() && m_k == m_n)) return 32'h0;
    v = m_rdata >> (8 * int'(m_addr[1:0]));
    if (eff_size() == 0) begin
      v = v % 256;
      if (!m_uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (eff_size() == 1) begin
      v = v % 65536;
      if (!m_uns && v >= 32768) v = v + 32'hFFFF0000;
    end else v = m_rdata;
    return v;
  endfunction
  function automatic logic [3:0] e_be();
    int lo = int'(m_addr[1:0]);
    if (eff_size() == 0) return 4'(1 << lo);
    if (eff_size() == 1) return 4'(3 << lo);
    return 4'hF;
  endfunction
  function automatic logic [31:0] e_wdata();
    if (eff_size() == 0) return (m_sd % 256) * 32'h01010101;
    if (eff_size() == 1) return (m_sd % 65536) * 32'h00010001;
    return m_sd;
  endfunction

  // Error-log model.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_v <= 0; sh_code <= 0; sh_addr <= 0;
    end else if (m_clr) begin
      sh_v <= 0; sh_code <= 0; sh_addr <= 0;
    end else if (!sh_v) begin
      if (m_mis()) begin
        sh_v <= 1; sh_code <= 2'd1; sh_addr <= m_addr;
      end else if (e_tocyc()) begin
        sh_v <= 1; sh_code <= 2'd2; sh_addr <= m_addr;
      end
    end
  end

  int          cap_stalls;
  bit          cap_req_seen, cap_rw_stall;
  logic [31:0] cap_rd, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_rwo, cap_req_end;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("dmem_req", dmem_req, e_req());
      chk("stall", stall, e_stall());
      chk("reg_write_o", reg_write_o, e_rwo());
      chk("read_data", read_data, e_rdata());
      if (e_req()) begin
        chk("dmem_addr", dmem_addr, m_addr & 32'hFFFFFFFC);
        chk("dmem_we", dmem_we, m_wr);
        chk("dmem_be", dmem_be, e_be());
        if (m_wr) chk("dmem_wdata", dmem_wdata, e_wdata());
      end
      chk("alu_out_o", alu_out_o, m_addr);
      chk("reg_wr_addr_o", reg_wr_addr_o, m_wa);
      chk("memto_reg_o", memto_reg_o, m_rd & ~m_wr);
      chk("err_valid", err_valid, sh_v);
      chk("err_code", err_code, sh_code);
      chk("err_addr", err_addr, sh_addr);
      if (stall) cap_stalls++;
      if (stall && reg_write_o) cap_rw_stall = 1;
      if (dmem_req) begin
        cap_req_seen = 1; cap_be = dmem_be; cap_wdata = dmem_wdata; cap_we = dmem_we;
      end
      if (m_k == last_k()) begin
        cap_rd = read_data; cap_rwo = reg_write_o; cap_req_end = dmem_req;
      end
    end
  end

  task automatic apply();
    alu_out = m_addr; store_data = m_sd; reg_wr_addr = m_wa; reg_write = m_rw;
    memto_reg = m_rd & ~m_wr; mem_read = m_rd; mem_write = m_wr; mem_size = m_size;
    mem_unsigned = m_uns; dmem_rdata = m_rdata; dmem_ready = (m_k == m_n);
    err_clr = m_clr;
  endtask

  task automatic set_idle();
    m_rd = 0; m_wr = 0; m_rw = 1; m_clr = 0; m_n = 0; m_k = 0; m_wa = 5'd0;
    apply();
  endtask

  // One transaction; returns at #1 after its last edge with idle inputs.
  task automatic run(input logic rd, input logic wr, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] sd, input logic uns,
                     input logic [31:0] rdata, input int n);
    @(posedge clk); #1;
    m_rd = rd; m_wr = wr; m_size = size; m_addr = addr; m_sd = sd; m_uns = uns;
    m_rdata = rdata; m_n = n; m_k = 0; m_rw = rd & ~wr; m_wa = 5'd9;
    m_clr = pend_clr; pend_clr = 0;
    cap_stalls = 0; cap_req_seen = 0; cap_rw_stall = 0;
    cap_be = 0; cap_wdata = 0; cap_we = 0; cap_rd = 0; cap_rwo = 0; cap_req_end = 0;
    apply();
    while (m_k < last_k()) begin
      @(posedge clk); #1;
      m_k++;
      apply();
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    reset = 1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst dmem_req", dmem_req, 1'b0);
    chk("rst stall", stall, 1'b0);
    chk("rst err_valid", err_valid, 1'b0);
    chk("rst err_code", err_code, 2'd0);
    chk("rst err_addr", err_addr, 32'h0);
    reset = 0;
    chk_en = 1;

    // lw zero-wait
    run(1, 0, 2'd2, 32'h100, 0, 0, 32'hDEADBEEF, 0);
    chk("lw rdata", cap_rd, 32'hDEADBEEF);
    chk("lw stalls", cap_stalls, 0);
    chk("lw reg_write_o", cap_rwo, 1'b1);
    // lb / lbu with 3 wait states
    run(1, 0, 2'd0, 32'h1003, 0, 0, 32'h80FF1234, 3);
    chk("lb stalls", cap_stalls, 3);
    chk("lb rdata", cap_rd, 32'hFFFFFF80);
    chk("lb rw during stall", cap_rw_stall, 1'b0);
    run(1, 0, 2'd0, 32'h1003, 0, 1, 32'h80FF1234, 3);
    chk("lbu rdata", cap_rd, 32'h00000080);
    // sh
    run(0, 1, 2'd1, 32'h2002, 32'h0000ABCD, 0, 0, 1);
    chk("sh be", cap_be, 4'b1100);
    chk("sh wdata", cap_wdata, 32'hABCDABCD);
    chk("sh we", cap_we, 1'b1);
    // additional patterns
    run(1, 0, 2'd1, 32'h0002, 0, 0, 32'h80010000, 1);
    chk("lh rdata", cap_rd, 32'hFFFF8001);
    run(1, 0, 2'd1, 32'h0000, 0, 1, 32'h1234F00F, 0);
    chk("lhu rdata", cap_rd, 32'h0000F00F);
    run(0, 1, 2'd0, 32'h0041, 32'h1122335A, 0, 0, 2);
    chk("sb be", cap_be, 4'b0010);
    chk("sb wdata", cap_wdata, 32'h5A5A5A5A);
    run(0, 1, 2'd3, 32'h0010, 32'hCAFEF00D, 0, 0, 0);
    chk("sw size3 be", cap_be, 4'hF);
    run(1, 1, 2'd2, 32'h0020, 32'h01020304, 0, 32'h55555555, 0);
    chk("rd+wr is store", cap_we, 1'b1);
    chk("rd+wr rdata", cap_rd, 32'h0);
    // ready exactly on the last allowed cycle completes normally
    run(1, 0, 2'd2, 32'h0040, 0, 0, 32'h0BADF00D, int'(TO));
    chk("edge stalls", cap_stalls, int'(TO));
    chk("edge rdata", cap_rd, 32'h0BADF00D);
    chk("edge no err", err_valid, 1'b0);
    // misaligned
    run(1, 0, 2'd2, 32'h3001, 0, 0, 32'h12345678, 0);
    chk("mis req", cap_req_seen, 1'b0);
    chk("mis err_valid", err_valid, 1'b1);
    chk("mis err_code", err_code, 2'd1);
    chk("mis err_addr", err_addr, 32'h3001);
    run(0, 1, 2'd1, 32'h2001, 32'h1, 0, 0, 0);
    chk("2nd err keeps addr", err_addr, 32'h3001);
    m_clr = 1; apply();
    @(posedge clk); #1;
    m_clr = 0; apply();
    chk("clr err_valid", err_valid, 1'b0);
    pend_clr = 1;
    run(1, 0, 2'd1, 32'h3003, 0, 0, 0, 0);
    chk("clr beats error", err_valid, 1'b0);
    // timeout
    run(1, 0, 2'd2, 32'h5000, 0, 0, 32'hFFFFFFFF, 100);
    chk("to stalls", cap_stalls, int'(TO));
    chk("to req dropped", cap_req_end, 1'b0);
    chk("to reg_write_o", cap_rwo, 1'b0);
    chk("to err_code", err_code, 2'd2);
    chk("to err_addr", err_addr, 32'h5000);

    // reset during the second WAIT cycle
    @(posedge clk); #1;
    m_rd = 1; m_wr = 0; m_size = 2'd2; m_addr = 32'h6000; m_n = 50; m_k = 0;
    m_rw = 1; m_wa = 5'd3; apply();
    repeat (2) begin
      @(posedge clk); #1;
      m_k++; apply();
    end
    #1;
    chk("pre-reset stall", stall, 1'b1);
    reset = 1;
    #1;
    chk("reset req drop", dmem_req, 1'b0);
    chk("reset stall drop", stall, 1'b0);
    set_idle();
    #1;
    reset = 0;
    chk("post-reset err_valid", err_valid, 1'b0);
    run(1, 0, 2'd2, 32'h0200, 0, 0, 32'h13579BDF, 0);
    chk("post-reset stalls", cap_stalls, 0);
    chk("post-reset rdata", cap_rd, 32'h13579BDF);

    repeat (2) @(posedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns load/store control into a request/ready transaction on the data-memory bus, and aligns and extends load data. While a memory access is outstanding it stalls the upstream pipeline and presents a bubble downstream. It also records misalignment and bus-timeout errors.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of wait cycles before a bus error is declared (1–255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- alu_out  in  32  ALU result / effective address, from EX/MEM
- store_data  in  32  rt value for stores
- reg_wr_addr  in  5  destination register
- reg_write  in  1  register write enable
- memto_reg  in  1  writeback selects memory data
- mem_read  in  1  load
- mem_write  in  1  store
- mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word (3 is treated as word)
- mem_unsigned  in  1  zero-extend load data
- dmem_addr  out  32  word-aligned address ({addr[31:2], 2'b00})
- dmem_req  out  1  request valid
- dmem_we  out  1  write
- dmem_be  out  4  byte enables; bit i selects lane i = addr bits 1:0 equal to i (little-endian)
- dmem_wdata  out  32  store data, replicated across lanes
- dmem_rdata  in  32  read data, valid when dmem_ready is high
- dmem_ready  in  1  transfer completes this cycle
- read_data  out  32  aligned and extended load data, to MEM/WB
- alu_out_o, reg_wr_addr_o, memto_reg_o  out  32/5/1  pass-through to MEM/WB
- reg_write_o  out  1  reg_write gated by bubble
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- err_valid  out  1  sticky error flag
- err_code  out  2  1 = misaligned, 2 = bus timeout
- err_addr  out  32  alu_out of the faulting access
- err_clr  in  1  clears err_valid, err_code and err_addr

## Operation
- Access = mem_read or mem_write. If both are high, it is treated as a store.
- Misaligned: half with addr[0] set, or word with addr[1:0] nonzero.
  - No bus request is issued.
  - reg_write_o = 0.
  - The error is logged. No stall.
- States:
  - IDLE: a valid aligned access drives dmem_req = 1 combinationally from the inputs.
    - If dmem_ready is high in the same cycle, the access completes with zero wait.
    - Otherwise go to WAIT and capture addr, we, be and wdata into request registers.
  - WAIT: bus outputs come from the request registers; dmem_req stays at 1. A wait counter increments each cycle.
    - dmem_ready → IDLE.
    - Counter reaches TIMEOUT without dmem_ready → IDLE, log a timeout error, drop dmem_req.
- stall = dmem_req & ~dmem_ready, excluding the timeout cycle.
- reg_write_o = reg_write & ~stall & ~misaligned & ~timeout_cycle.
- Store encoding:
  - byte: be = 1 << addr[1:0], wdata = {4{sd[7:0]}}.
  - half: be = 4'b0011 << addr[1:0], wdata = {2{sd[15:0]}}.
  - word: be = 4'hF, wdata = sd.
- Load alignment: select the lane(s) at addr[1:0], then sign-extend, or zero-extend when mem_unsigned is high. read_data = dmem_rdata lanes when a load completes; 0 otherwise.
- Error log:
  - Written on an error only when err_valid is 0; the first error wins.
  - err_clr has priority over a new error in the same cycle.

## Timing
- Datapath to MEM/WB is combinational. MEM/WB captures on the dmem_ready cycle.
- Zero-wait access: 0 stall cycles. N wait states: N stall cycles.
- Timeout: TIMEOUT stall cycles, then one non-stalled cycle in which err_valid rises on the next edge.
- Reset values (asynchronous):
  - state = IDLE, wait counter = 0, request registers = 0.
  - err_valid = 0, err_code = 0, err_addr = 0.
  - Combinational outputs follow the IDLE equations.
- Reset asserted in WAIT: dmem_req falls immediately and stall drops. The bus slave must tolerate an abandoned request.
- Inputs are ignored in WAIT because upstream is frozen by stall.

## Structure
- Package mem_pkg holds:
  - SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT.
  - The state enum {IDLE, WAIT}.
- Sub-module mem_lane_align (combinational) does:
  - store byte-enable and wdata generation,
  - load lane select and extend,
  - misalignment detect.
- The top level holds the FSM, wait counter, request registers and error log.

## Test plan
- lw at 0x100, dmem_ready high on the request cycle → read_data = dmem_rdata = 0xDEADBEEF, stall never high, reg_write_o = 1.
- lb at 0x1003, 3 wait states, rdata 0x80FF1234 → stall high for 3 cycles, read_data = 0xFFFFFF80, reg_write_o = 0 during the stall. Repeat as lbu → 0x00000080.
- sh at 0x2002 with store_data 0x0000ABCD → be = 4'b1100, wdata = 0xABCDABCD, dmem_we = 1.
- lw at 0x3001 → no dmem_req, err_valid = 1, err_code = 1, err_addr = 0x3001. A second error leaves the log unchanged. err_clr → 0.
- TIMEOUT = 4, dmem_ready held low → 4 stall cycles, dmem_req drops, err_code = 2, reg_write_o = 0.
- reset asserted in the 2nd WAIT cycle → dmem_req and stall drop immediately. After release: IDLE, err_valid = 0.
